// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline freeze/bubble/flush controller.
// Stage enable bundle ordered from PC down to the flush strobe.
package pipeline_stall_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic id_ex_nop;
    logic if_id_flush;
  } stage_en_t;

  localparam stage_en_t EN_FREEZE = '{
    load_pc: 1'b0, if_id: 1'b0, id_ex: 1'b0,
    ex_mem: 1'b0, mem_wb: 1'b0,
    id_ex_nop: 1'b0, if_id_flush: 1'b0
  };

  localparam stage_en_t EN_RESET = '{
    load_pc: 1'b0, if_id: 1'b0, id_ex: 1'b0,
    ex_mem: 1'b0, mem_wb: 1'b0,
    id_ex_nop: 1'b1, if_id_flush: 1'b1
  };

  localparam stage_en_t EN_ADVANCE = '{
    load_pc: 1'b1, if_id: 1'b1, id_ex: 1'b1,
    ex_mem: 1'b1, mem_wb: 1'b1,
    id_ex_nop: 1'b0, if_id_flush: 1'b0
  };

  localparam stage_en_t EN_REDIRECT = '{
    load_pc: 1'b1, if_id: 1'b1, id_ex: 1'b1,
    ex_mem: 1'b1, mem_wb: 1'b1,
    id_ex_nop: 1'b1, if_id_flush: 1'b1
  };

  // Hold PC and IF/ID, inject a bubble into ID/EX, let the back end drain.
  localparam stage_en_t EN_LOAD_USE = '{
    load_pc: 1'b0, if_id: 1'b0, id_ex: 1'b1,
    ex_mem: 1'b1, mem_wb: 1'b1,
    id_ex_nop: 1'b1, if_id_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/bubble/flush policy for the 5-stage pipe: cache-miss freeze,
// load-use bubble and branch redirect, with deferred redirect on freeze.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hz_stall,
  input  logic                 br_redirect,
  input  logic                 icache_read,
  input  logic                 icache_resp,
  input  logic                 dcache_req,
  input  logic                 dcache_resp,
  output logic                 load_pc,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 id_ex_nop,
  output logic                 if_id_flush,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  pipe_ctrl_state_t state_q, state_d;
  logic i_done_q, i_done_d;
  logic d_done_q, d_done_d;
  logic flush_pend_q, flush_pend_d;

  logic i_miss, d_miss, miss;
  logic redirect;
  logic flush_inc;
  stage_en_t en;

  assign i_miss = icache_read & ~icache_resp & ~i_done_q;
  assign d_miss = dcache_req & ~dcache_resp & ~d_done_q;
  assign miss   = i_miss | d_miss;
  assign redirect = br_redirect | flush_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    flush_pend_d = 1'b0;
    if (miss) begin
      state_d  = MEM_WAIT;
      // Done flags only carry history across a wait, never out of RUN.
      i_done_d = (state_q == MEM_WAIT && i_done_q) | icache_resp;
      d_done_d = (state_q == MEM_WAIT && d_done_q) | dcache_resp;
      flush_pend_d = flush_pend_q | br_redirect;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    en = EN_ADVANCE;
    if (rst) begin
      en = EN_RESET;
    end else if (miss) begin
      en = EN_FREEZE;
    end else if (redirect) begin
      en = EN_REDIRECT;
    end else if (hz_stall) begin
      en = EN_LOAD_USE;
    end
  end

  assign load_pc     = en.load_pc;
  assign if_id_load  = en.if_id;
  assign id_ex_load  = en.id_ex;
  assign ex_mem_load = en.ex_mem;
  assign mem_wb_load = en.mem_wb;
  assign id_ex_nop   = en.id_ex_nop;
  assign if_id_flush = en.if_id_flush;

  assign flush_inc = ~miss & redirect;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss),
    .count (stall_count)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
